// File: rtl/wb_drain_pkg.sv
// Shared types and constants for the write-buffer drain stage.
//
// Contents:
//   drain_state_t - drain FSM state encoding
//   WORDS_DEF     - default number of words per buffer line
//   IDX_W         - word index width for the default line size
package wb_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DONE   = 2'd2,
        SETTLE = 2'd3
    } drain_state_t;

    localparam int WORDS_DEF = 4;
    localparam int IDX_W     = $clog2(WORDS_DEF);

endpackage

// File: rtl/wb_lowest_set.sv
// Combinational priority encoder. Returns the index of the lowest set bit
// of a word-valid mask. It is used to pick the next word of a line to write.
//
// Ports:
//   mask  in   WORDS  per-word valid bits
//   idx   out  IDX_W  index of the lowest set bit (0 when mask is zero)
//   any   out  1      mask has at least one bit set
module wb_lowest_set #(
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic [WORDS-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_drain.sv
// Write-buffer drain stage. It snapshots the head line presented by the
// write buffer and writes each valid word to memory, one word per req/ack
// transaction. It then pulses line_done for one cycle so the buffer can
// retire the head entry.
//
// Build option: define WB_DRAIN_TIMEOUT_EN to abandon a word after
// TIMEOUT_CYCLES cycles without mem_ack. In that case the sticky
// err_timeout flag is set. When the macro is undefined, the drain waits
// for mem_ack indefinitely and err_timeout is tied low.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   line_pending  in   buffer holds a line (head is valid)
//   line_addr     in   per-word addresses of the head line
//   line_data     in   per-word data of the head line
//   line_wvalid   in   per-word valid bits of the head line
//   line_done     out  one-cycle pulse, head line fully written
//   mem_req       out  memory write request
//   mem_we        out  write enable (mirrors mem_req)
//   mem_addr      out  write address
//   mem_wdata     out  write data
//   mem_ack       in   memory accepted the current word
//   busy          out  drain is not idle
//   err_timeout   out  sticky timeout flag
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | wait for line_pending, snapshot the head line
// ISSUE  | present the lowest remaining word until it is acked
// DONE   | line_done pulse
// SETTLE | one idle cycle while the buffer advances its head
module wb_mem_drain
    import wb_drain_pkg::*;
#(
    parameter int WORDS          = WORDS_DEF,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          line_pending,
    input  logic [WORDS-1:0][ADDR_W-1:0]  line_addr,
    input  logic [WORDS-1:0][DATA_W-1:0]  line_data,
    input  logic [WORDS-1:0]              line_wvalid,
    output logic                          line_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int SEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    drain_state_t                 state;
    logic [WORDS-1:0][ADDR_W-1:0] snap_addr;
    logic [WORDS-1:0][DATA_W-1:0] snap_data;
    logic [WORDS-1:0]             snap_mask;
    logic [SEL_W-1:0]             cur_idx;

    logic [WORDS-1:0]             mask_left;
    logic [WORDS-1:0]             enc_mask;
    logic [SEL_W-1:0]             sel_idx;
    logic                         sel_any;
    logic                         tmo_hit;

    // One encoder serves both cases. In IDLE it picks the first word of the
    // incoming line. In ISSUE it picks the word that follows the current one.
    assign mask_left = snap_mask & ~(WORDS'(1) << cur_idx);
    assign enc_mask  = (state == IDLE) ? line_wvalid : mask_left;

    wb_lowest_set #(
        .WORDS (WORDS),
        .IDX_W (SEL_W)
    ) u_sel (
        .mask (enc_mask),
        .idx  (sel_idx),
        .any  (sel_any)
    );

`ifdef WB_DRAIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] wait_cnt;
    logic             err_q;

    // The down-counter is reloaded whenever no word is waiting. Terminal
    // count 1 means the word has been presented TIMEOUT_CYCLES cycles.
    assign tmo_hit = (state == ISSUE) && mem_req && !mem_ack && (wait_cnt == TMO_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= TMO_W'(TIMEOUT_CYCLES);
            err_q    <= 1'b0;
        end else begin
            if ((state != ISSUE) || !mem_req || mem_ack || tmo_hit)
                wait_cnt <= TMO_W'(TIMEOUT_CYCLES);
            else
                wait_cnt <= wait_cnt - TMO_W'(1);
            if (tmo_hit)
                err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap_addr <= '0;
            snap_data <= '0;
            snap_mask <= '0;
            cur_idx   <= '0;
            line_done <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_pending) begin
                        snap_addr <= line_addr;
                        snap_data <= line_data;
                        snap_mask <= line_wvalid;
                        busy      <= 1'b1;
                        if (sel_any) begin
                            // The first word comes straight from the inputs.
                            // The snapshot is only loaded on this same edge.
                            state     <= ISSUE;
                            cur_idx   <= sel_idx;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= line_addr[sel_idx];
                            mem_wdata <= line_data[sel_idx];
                        end else begin
                            state     <= DONE;
                            line_done <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (!mem_req) begin
                        // Re-raise the request after a dropped (abandoned) word.
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else if (mem_ack || tmo_hit) begin
                        snap_mask <= mask_left;
                        if (sel_any) begin
                            cur_idx   <= sel_idx;
                            mem_addr  <= snap_addr[sel_idx];
                            mem_wdata <= snap_data[sel_idx];
                            if (tmo_hit) begin
                                mem_req <= 1'b0;
                                mem_we  <= 1'b0;
                            end
                        end else begin
                            state     <= DONE;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            line_done <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    line_done <= 1'b0;
                    state     <= SETTLE;
                end

                SETTLE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_drain.sv
module tb_wb_mem_drain;

    localparam int WORDS  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;
`ifdef WB_DRAIN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         line_pending;
    logic [WORDS-1:0][ADDR_W-1:0] line_addr;
    logic [WORDS-1:0][DATA_W-1:0] line_data;
    logic [WORDS-1:0]             line_wvalid;
    logic                         line_done;
    logic                         mem_req;
    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         mem_ack;
    logic                         busy;
    logic                         err_timeout;

    int checks = 0;
    int errors = 0;
    bit err_model = 1'b0;

    wb_mem_drain #(
        .WORDS          (WORDS),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_pending (line_pending),
        .line_addr    (line_addr),
        .line_data    (line_data),
        .line_wvalid  (line_wvalid),
        .line_done    (line_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drains one line and checks it against a transaction-level model.
    // The expected words are the valid words in ascending index order, and a
    // word acked after d wait cycles occupies d+1 cycles. With the timeout
    // feature, a word that is never acked occupies TMO cycles, plus one
    // dropped-request cycle when another word follows it. DONE and SETTLE
    // add 2 cycles. line_done appears in the second-to-last busy cycle.
    task automatic run_line(input string tag,
                            input logic [WORDS-1:0][ADDR_W-1:0] a,
                            input logic [WORDS-1:0][DATA_W-1:0] d,
                            input logic [WORDS-1:0] m,
                            input int dly [WORDS]);
        logic [ADDR_W-1:0] qa[$];
        logic [DATA_W-1:0] qd[$];
        int dq[$];
        int exp_busy = 2;
        int busy_n   = 0;
        int done_n   = 0;
        int done_at  = -1;
        int wait_n   = 0;
        int cyc      = 0;
        bit finished = 1'b0;
        bit exp_err  = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            if (m[i]) begin
                qa.push_back(a[i]);
                qd.push_back(d[i]);
                dq.push_back(dly[i]);
            end
        end
        for (int j = 0; j < dq.size(); j++) begin
            if (TMO_EN && dq[j] >= TMO) begin
                exp_busy += TMO + ((j < dq.size() - 1) ? 1 : 0);
                exp_err = 1'b1;
            end else begin
                exp_busy += dq[j] + 1;
            end
        end
        err_model = err_model | exp_err;

        line_addr    = a;
        line_data    = d;
        line_wvalid  = m;
        line_pending = 1'b1;
        mem_ack      = 1'b0;

        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!busy) begin
                finished = 1'b1;
            end else begin
                busy_n++;
                if (busy_n == 1) begin
                    // The line is now captured; disturb the live inputs.
                    line_pending = 1'b0;
                    line_addr    = {$urandom, $urandom, $urandom, $urandom};
                    line_data    = {$urandom, $urandom, $urandom, $urandom};
                    line_wvalid  = WORDS'($urandom);
                end
                if (line_done) begin
                    done_n++;
                    done_at = busy_n;
                end
                if (mem_req) begin
                    if (qa.size() == 0) begin
                        chk({tag, "_extra_req"}, mem_req, 1'b0);
                        mem_ack = 1'b1;
                    end else begin
                        chk({tag, "_addr"}, mem_addr, qa[0]);
                        chk({tag, "_data"}, mem_wdata, qd[0]);
                        chk({tag, "_we"}, mem_we, 1'b1);
                        if (wait_n >= dq[0]) begin
                            mem_ack = 1'b1;
                            void'(qa.pop_front());
                            void'(qd.pop_front());
                            void'(dq.pop_front());
                            wait_n = 0;
                        end else if (TMO_EN && wait_n == TMO - 1) begin
                            mem_ack = 1'b0;
                            void'(qa.pop_front());
                            void'(qd.pop_front());
                            void'(dq.pop_front());
                            wait_n = 0;
                        end else begin
                            mem_ack = 1'b0;
                            wait_n++;
                        end
                    end
                end else begin
                    mem_ack = 1'($urandom_range(0, 1));
                end
            end
        end
        mem_ack = 1'b0;
        chk({tag, "_bound"}, finished, 1'b1);
        chk({tag, "_busy_cycles"}, busy_n, exp_busy);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_cycle"}, done_at, exp_busy - 1);
        chk({tag, "_words_left"}, qa.size(), 0);
        chk({tag, "_err"}, err_timeout, err_model);
    endtask

    initial begin
        int dly [WORDS];
        logic [WORDS-1:0][ADDR_W-1:0] a;
        logic [WORDS-1:0][DATA_W-1:0] d;
        logic [WORDS-1:0]             m;

        rst          = 1'b1;
        line_pending = 1'b0;
        line_addr    = '0;
        line_data    = '0;
        line_wvalid  = '0;
        mem_ack      = 1'b0;

        #12;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_done", line_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_err", err_timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full line, ack held high.
        a = {32'h103, 32'h102, 32'h101, 32'h100};
        d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        dly = '{0, 0, 0, 0};
        run_line("full", a, d, 4'b1111, dly);

        // Sparse line with delayed acks.
        a = {32'h203, 32'h202, 32'h201, 32'h200};
        d = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        dly = '{3, 3, 3, 3};
        run_line("sparse", a, d, 4'b0101, dly);

        // Empty mask: retired without memory traffic.
        run_line("empty", a, d, 4'b0000, dly);

        // Reset after the first of three words is acked.
        @(negedge clk);
        a = {32'h303, 32'h302, 32'h301, 32'h300};
        d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        line_addr    = a;
        line_data    = d;
        line_wvalid  = 4'b0111;
        line_pending = 1'b1;
        mem_ack      = 1'b1;
        @(negedge clk);
        chk("rstmid_addr0", mem_addr, 32'h300);
        @(negedge clk);
        chk("rstmid_addr1", mem_addr, 32'h301);
        mem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstmid_req", mem_req, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", line_done, 1'b0);
        @(negedge clk);
        chk("rstmid_done_held", line_done, 1'b0);
        rst = 1'b0;
        dly = '{0, 1, 0, 0};
        run_line("redrain", a, d, 4'b0111, dly);

        // Randomized lines.
        for (int n = 0; n < 8; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            m = WORDS'($urandom);
            for (int i = 0; i < WORDS; i++) dly[i] = $urandom_range(0, 3);
            run_line($sformatf("rand%0d", n), a, d, m, dly);
        end

`ifdef WB_DRAIN_TIMEOUT_EN
        // Second word never acked: abandoned, sticky error, line still done.
        a = {32'h403, 32'h402, 32'h401, 32'h400};
        d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        dly = '{0, 1000, 0, 0};
        run_line("timeout", a, d, 4'b0011, dly);
        dly = '{1000, 0, 0, 0};
        run_line("timeout_mid", a, d, 4'b0011, dly);
        dly = '{1, 0, 2, 0};
        run_line("after_tmo", a, d, 4'b1101, dly);
`endif

        repeat (3) @(negedge clk);
        chk("idle_req", mem_req, 1'b0);
        chk("idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
